// File: rtl/a2d_pkg.sv
// ----------------------------------------------------------------------------
// a2d_pkg
// Shared definitions for the A2D conversion scheduler: the scheduler state
// encoding, the default A2D channel addresses of the four sensors, and the
// fields used to build an SPI read command {opcode, channel, pad}.
// No ports (package).
// ----------------------------------------------------------------------------
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT1,
        GAP,
        READ,
        WAIT2
    } a2d_state_t;

    // Default A2D channel addresses for each sensor
    localparam logic [2:0] A2D_CH_LFT   = 3'd0;
    localparam logic [2:0] A2D_CH_RGHT  = 3'd4;
    localparam logic [2:0] A2D_CH_STEER = 3'd5;
    localparam logic [2:0] A2D_CH_BATT  = 3'd6;

    // Round-robin pointer values, in sweep order
    localparam logic [1:0] PTR_LFT   = 2'd0;
    localparam logic [1:0] PTR_RGHT  = 2'd1;
    localparam logic [1:0] PTR_STEER = 2'd2;
    localparam logic [1:0] PTR_BATT  = 2'd3;

    // Read command layout: {A2D_RD_OP, channel[2:0], A2D_CMD_PAD}
    localparam logic [1:0]  A2D_RD_OP   = 2'b00;
    localparam logic [10:0] A2D_CMD_PAD = 11'h000;

endpackage

// File: rtl/a2d_conv_sched.sv
// ----------------------------------------------------------------------------
// a2d_conv_sched
// Round-robin conversion scheduler sitting between the balance/steering logic
// and the shared SPI master. Each nxt request runs one conversion on the next
// channel (left load, right load, steer pot, battery): a command frame whose
// reply is stale and thrown away, a one-clock CS-high gap, then a second frame
// with the same command whose reply holds the result.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   nxt        in   one-clock request to start the next conversion
//   done       in   SPI transaction-complete pulse
//   rd_data    in   [15:0] SPI receive word, valid with done
//   wrt        out  one-clock start pulse to the SPI master
//   cmd        out  [15:0] SPI transmit word
//   lft_ld     out  [11:0] left load-cell result
//   rght_ld    out  [11:0] right load-cell result
//   steer_pot  out  [11:0] steer pot result
//   batt       out  [11:0] battery result
//   busy       out  conversion in progress
//   sweep_done out  one-clock pulse when the battery result is captured
//   err        out  one-clock pulse when a transaction times out
// ----------------------------------------------------------------------------
module a2d_conv_sched
    import a2d_pkg::*;
#(
    parameter int         TIMEOUT  = 1023,
    parameter logic [2:0] CH_LFT   = A2D_CH_LFT,
    parameter logic [2:0] CH_RGHT  = A2D_CH_RGHT,
    parameter logic [2:0] CH_STEER = A2D_CH_STEER,
    parameter logic [2:0] CH_BATT  = A2D_CH_BATT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        sweep_done,
    output logic        err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    // The counter is still one short of TIMEOUT on the clock it would reach
    // it, so the abort lands exactly TIMEOUT clocks into a wait state.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    a2d_state_t       state;
    logic [1:0]       ptr;
    logic [TMR_W-1:0] tmr;
    logic [2:0]       chnl;
    logic             timed_out;

    // Only the 12-bit conversion result is kept; the upper reply bits are
    // don't-care from the A2D.
    logic unused_rd_hi;
    assign unused_rd_hi = &{1'b0, rd_data[15:12]};

    always_comb begin
        chnl = CH_LFT;
        case (ptr)
            PTR_LFT:   chnl = CH_LFT;
            PTR_RGHT:  chnl = CH_RGHT;
            PTR_STEER: chnl = CH_STEER;
            PTR_BATT:  chnl = CH_BATT;
            default:   chnl = CH_LFT;
        endcase
    end

    assign timed_out = (tmr == TMR_LAST);

    // In both wait states done takes priority over the timeout, so a reply
    // arriving on the expiry clock still completes normally. A timeout leaves
    // ptr alone so the same channel is retried on the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= PTR_LFT;
            tmr        <= '0;
            wrt        <= 1'b0;
            cmd        <= 16'h0000;
            lft_ld     <= 12'h000;
            rght_ld    <= 12'h000;
            steer_pot  <= 12'h000;
            batt       <= 12'h000;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            wrt        <= 1'b0;
            sweep_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt) begin
                        wrt   <= 1'b1;
                        cmd   <= {A2D_RD_OP, chnl, A2D_CMD_PAD};
                        tmr   <= '0;
                        busy  <= 1'b1;
                        state <= CMD;
                    end
                end
                CMD: begin
                    state <= WAIT1;
                end
                WAIT1: begin
                    if (done) begin
                        state <= GAP;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                GAP: begin
                    wrt   <= 1'b1;
                    tmr   <= '0;
                    state <= READ;
                end
                READ: begin
                    state <= WAIT2;
                end
                WAIT2: begin
                    if (done) begin
                        case (ptr)
                            PTR_LFT:   lft_ld    <= rd_data[11:0];
                            PTR_RGHT:  rght_ld   <= rd_data[11:0];
                            PTR_STEER: steer_pot <= rd_data[11:0];
                            default:   batt      <= rd_data[11:0];
                        endcase
                        sweep_done <= (ptr == PTR_BATT);
                        ptr        <= ptr + 2'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_conv_sched.sv
// ----------------------------------------------------------------------------
// tb_a2d_conv_sched
// Directed bench for a2d_conv_sched with the default parameters. The bench
// plays the SPI master: it answers each wrt with a done pulse at a fixed
// point, drives inputs on the falling edge and samples outputs there too.
// A table holds one full sweep of four conversions with the expected command
// words and result registers; hand-written sequences cover the timeout,
// done-on-expiry, ignored nxt, bit trimming and mid-conversion reset cases.
// ----------------------------------------------------------------------------
module tb_a2d_conv_sched;

    logic        clk;
    logic        rst_n;
    logic        nxt;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        busy;
    logic        sweep_done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] reply;
        logic [15:0] expCmd;
        logic [11:0] expLft;
        logic [11:0] expRght;
        logic [11:0] expSteer;
        logic [11:0] expBatt;
        logic        expSweep;
    } vec_t;

    vec_t vecs[4];

    a2d_conv_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nxt        (nxt),
        .done       (done),
        .rd_data    (rd_data),
        .wrt        (wrt),
        .cmd        (cmd),
        .lft_ld     (lft_ld),
        .rght_ld    (rght_ld),
        .steer_pot  (steer_pot),
        .batt       (batt),
        .busy       (busy),
        .sweep_done (sweep_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check funnels through here
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " wrt"},        16'(wrt),        16'h0);
        checkOutput({tag, " cmd"},        cmd,             16'h0000);
        checkOutput({tag, " busy"},       16'(busy),       16'h0);
        checkOutput({tag, " sweep_done"}, 16'(sweep_done), 16'h0);
        checkOutput({tag, " err"},        16'(err),        16'h0);
        checkOutput({tag, " lft_ld"},     16'(lft_ld),     16'h000);
        checkOutput({tag, " rght_ld"},    16'(rght_ld),    16'h000);
        checkOutput({tag, " steer_pot"},  16'(steer_pot),  16'h000);
        checkOutput({tag, " batt"},       16'(batt),       16'h000);
    endtask

    // Issue nxt and walk the first frame, gap and second wrt. Returns at the
    // falling edge just after the scheduler has entered WAIT2. extraNxt
    // raises nxt again while the scheduler sits in WAIT1.
    task automatic startConv(input logic [15:0] expCmd, input bit extraNxt,
                             input string tag);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        checkOutput({tag, " wrt first"},  16'(wrt),  16'h1);
        checkOutput({tag, " cmd first"},  cmd,       expCmd);
        checkOutput({tag, " busy CMD"},   16'(busy), 16'h1);
        @(negedge clk);
        checkOutput({tag, " wrt WAIT1"},  16'(wrt),  16'h0);
        done    = 1'b1;
        rd_data = 16'hDEAD;
        nxt     = extraNxt;
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
        nxt     = 1'b0;
        checkOutput({tag, " wrt GAP"},    16'(wrt),        16'h0);
        checkOutput({tag, " sweep GAP"},  16'(sweep_done), 16'h0);
        @(negedge clk);
        checkOutput({tag, " wrt second"}, 16'(wrt),  16'h1);
        checkOutput({tag, " cmd second"}, cmd,       expCmd);
        @(negedge clk);
        checkOutput({tag, " wrt WAIT2"},  16'(wrt),  16'h0);
        checkOutput({tag, " busy WAIT2"}, 16'(busy), 16'h1);
    endtask

    // Deliver the second done and check the completion flags
    task automatic finishConv(input logic [15:0] reply, input logic expSweep,
                              input string tag);
        done    = 1'b1;
        rd_data = reply;
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
        checkOutput({tag, " busy end"},  16'(busy),       16'h0);
        checkOutput({tag, " sweep end"}, 16'(sweep_done), 16'(expSweep));
        checkOutput({tag, " err end"},   16'(err),        16'h0);
        @(negedge clk);
        checkOutput({tag, " sweep after"}, 16'(sweep_done), 16'h0);
        checkOutput({tag, " wrt idle"},    16'(wrt),        16'h0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        startConv(v.expCmd, 1'b0, tag);
        finishConv(v.reply, v.expSweep, tag);
        checkOutput({tag, " lft_ld"},    16'(lft_ld),    16'(v.expLft));
        checkOutput({tag, " rght_ld"},   16'(rght_ld),   16'(v.expRght));
        checkOutput({tag, " steer_pot"}, 16'(steer_pot), 16'(v.expSteer));
        checkOutput({tag, " batt"},      16'(batt),      16'(v.expBatt));
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h0111, 16'h0000, 12'h111, 12'h000, 12'h000, 12'h000, 1'b0};
        vecs[1] = '{16'h0222, 16'h2000, 12'h111, 12'h222, 12'h000, 12'h000, 1'b0};
        vecs[2] = '{16'h0333, 16'h2800, 12'h111, 12'h222, 12'h333, 12'h000, 1'b0};
        vecs[3] = '{16'h0444, 16'h3000, 12'h111, 12'h222, 12'h333, 12'h444, 1'b1};

        rst_n   = 1'b0;
        nxt     = 1'b0;
        done    = 1'b0;
        rd_data = 16'h0000;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single conversion on the left load cell
        startConv(16'h0000, 1'b0, "first");
        finishConv(16'h0ABC, 1'b0, "first");
        checkOutput("first lft_ld", 16'(lft_ld), 16'h0ABC);

        // One full sweep from a fresh pointer
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], $sformatf("sweep%0d", i));
        end

        // Withhold the second done: abort after TIMEOUT clocks in WAIT2
        $display("[TB] timeout on left channel");
        startConv(16'h0000, 1'b0, "timeout");
        repeat (1022) @(negedge clk);
        checkOutput("timeout err early",  16'(err),  16'h0);
        checkOutput("timeout busy early", 16'(busy), 16'h1);
        @(negedge clk);
        checkOutput("timeout err",    16'(err),    16'h1);
        checkOutput("timeout busy",   16'(busy),   16'h0);
        checkOutput("timeout lft_ld", 16'(lft_ld), 16'h0111);
        @(negedge clk);
        checkOutput("timeout err pulse", 16'(err), 16'h0);

        // Retry hits the same channel; an nxt during WAIT1 is dropped
        startConv(16'h0000, 1'b1, "retry");
        finishConv(16'h0765, 1'b0, "retry");
        checkOutput("retry lft_ld",  16'(lft_ld),  16'h0765);
        checkOutput("retry rght_ld", 16'(rght_ld), 16'h0222);
        repeat (3) @(negedge clk);
        checkOutput("retry no extra wrt", 16'(wrt),  16'h0);
        checkOutput("retry idle busy",    16'(busy), 16'h0);

        // Upper reply bits are dropped
        startConv(16'h2000, 1'b0, "trim");
        finishConv(16'hF800, 1'b0, "trim");
        checkOutput("trim rght_ld", 16'(rght_ld), 16'h0800);

        // done on the expiry clock counts as a normal completion
        startConv(16'h2800, 1'b0, "donewins");
        repeat (1022) @(negedge clk);
        done    = 1'b1;
        rd_data = 16'h0C3C;
        @(negedge clk);
        done    = 1'b0;
        rd_data = 16'h0000;
        checkOutput("donewins err",       16'(err),       16'h0);
        checkOutput("donewins busy",      16'(busy),      16'h0);
        checkOutput("donewins steer_pot", 16'(steer_pot), 16'h0C3C);

        // Asynchronous reset in WAIT2 of the battery conversion
        startConv(16'h3000, 1'b0, "midrst");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetState("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        startConv(16'h0000, 1'b0, "postrst");
        finishConv(16'h0321, 1'b0, "postrst");
        checkOutput("postrst lft_ld", 16'(lft_ld), 16'h0321);
        checkOutput("postrst batt",   16'(batt),   16'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/a2d_conv_sched.md
# a2d_conv_sched

Round-robin conversion scheduler between the balance/steering logic and the shared SPI master driving the external 8-channel A2D. Each `nxt` request runs one two-transaction SPI conversion on the next channel in the fixed sequence left load, right load, steer pot, battery. The result is captured into a per-channel 12-bit holding register. The `lft_ld`/`rght_ld` outputs feed the steering-enable and rider-detect logic directly.

## Interface
- `TIMEOUT`, default 1023: clocks to wait for SPI `done` before aborting a transaction.
- `CH_LFT`, default 3'd0: A2D channel for the left load cell.
- `CH_RGHT`, default 3'd4: A2D channel for the right load cell.
- `CH_STEER`, default 3'd5: A2D channel for the steer pot.
- `CH_BATT`, default 3'd6: A2D channel for the battery.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `nxt`, in, 1: one-clock request to start the next conversion.
- `done`, in, 1: SPI master transaction-complete pulse.
- `rd_data`, in, 16: SPI receive word, valid when `done` is high.
- `wrt`, out, 1: one-clock start pulse to the SPI master.
- `cmd`, out, 16: SPI transmit word.
- `lft_ld`, out, 12: left load-cell result.
- `rght_ld`, out, 12: right load-cell result.
- `steer_pot`, out, 12: steer pot result.
- `batt`, out, 12: battery result.
- `busy`, out, 1: a conversion is in progress.
- `sweep_done`, out, 1: one-clock pulse when the battery result is captured.
- `err`, out, 1: one-clock pulse on a timeout abort.

## Operation
- Channel pointer `ptr` (2 bits) selects lft → rght → steer → batt → lft. Reset value 0 (lft).
- States: IDLE, CMD, WAIT1, GAP, READ, WAIT2.
- IDLE, `nxt` high: assert `wrt`; `cmd` = {2'b00, chnl[2:0], 11'h000}; go to CMD.
- CMD: go to WAIT1 unconditionally. The `wrt` pulse is exactly one clock.
- WAIT1, `done` high: go to GAP. `rd_data` is discarded; it holds the previous frame's data.
- GAP: one idle clock, giving the A2D CS-high time. Then assert `wrt` with the same `cmd` and go to READ.
- READ: go to WAIT2.
- WAIT2, `done` high: capture `rd_data[11:0]` into the register selected by `ptr`. Increment `ptr` (2-bit wrap). Return to IDLE. If `ptr` was 3, pulse `sweep_done` in the same clock.
- Timeout counter: cleared on every `wrt`, increments in WAIT1 and WAIT2. When it reaches `TIMEOUT` before `done`:
  - pulse `err`;
  - go to IDLE with no capture;
  - do not advance `ptr`, so the same channel is retried on the next `nxt`.
- `nxt` while `busy` is ignored; it is not queued.
- `done` in IDLE, CMD, GAP or READ is ignored.
- `done` arriving in the same clock the timeout expires: `done` wins and is treated as a normal completion.
- `busy` is high in every state except IDLE.

## Timing
- Reset values: all result registers 12'h000; `wrt`, `busy`, `sweep_done`, `err` = 0; `cmd` = 16'h0000; state IDLE.
- Reset is asynchronous mid-conversion: state and outputs return to reset values immediately. No partial capture is kept.
- `wrt` and `cmd` are registered. `wrt` goes high the clock after `nxt` is sampled, and `cmd` is stable from that edge until the next `wrt`.
- Second `wrt` occurs exactly 2 clocks after the first `done` is sampled.
- Result register updates on the clock edge after the second `done` is sampled. `sweep_done` is high in that same clock.
- Minimum `nxt` spacing for back-to-back conversions is the SPI frame time ×2 plus 4 clocks.

## Structure
- Shared package `a2d_pkg`:
  - state enum `a2d_state_t`;
  - channel address localparams;
  - command-format helper constants (read opcode 2'b00, pad 11'h000).
- Single module, no sub-module. The timeout counter is inline, sized by $clog2(TIMEOUT+1).
- The SPI master is an external existing block, instantiated by the parent.

## Test plan
- Reset then one `nxt`:
  - `wrt` pulses with `cmd`=16'h0000;
  - after the two `done`s with `rd_data`=16'h0ABC, `lft_ld`=12'hABC and `busy` falls.
- Four `nxt` requests with replies 0x111, 0x222, 0x333, 0x444:
  - the four `cmd` values are 16'h0000, 16'h2000, 16'h2800, 16'h3000;
  - `sweep_done` pulses once, on the battery capture.
- `nxt` asserted during WAIT1: no extra `wrt`, `ptr` unchanged, and only one capture occurs.
- Withhold `done` in WAIT2:
  - `err` pulses after 1023 clocks, `lft_ld` holds its old value;
  - the next `nxt` re-issues `cmd`=16'h0000.
- Assert `rst_n` low during WAIT2: all outputs go to 0 immediately, and the next `nxt` targets channel 0.
- `rd_data`=16'hF800 on the second `done`: only the low 12 bits are captured, giving 12'h800.
